// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester and memory-side signal bundle for the arbiter
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        m_valid;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           m_valid, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           m_valid, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - registered fetch/data arbiter for a single-port memory
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [9:0] TCNT_LAST  = 10'(TIMEOUT - 1);

  state_t      state;
  logic        own;
  logic [3:0]  streak;
  logic [9:0]  tcnt;

  logic        any_req;
  logic        d_win;

  assign any_req = bus.i_req | bus.d_req;
  // Data wins ties until it has taken MAX_D_STREAK grants in a row past a waiting fetch.
  assign d_win   = bus.d_req & ~(bus.i_req & (streak == STREAK_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      own         <= 1'b0;
      streak      <= 4'd0;
      tcnt        <= 10'd0;
      bus.m_valid <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= 32'd0;
      bus.m_wdata <= 32'd0;
      bus.i_ack   <= 1'b0;
      bus.i_err   <= 1'b0;
      bus.i_rdata <= 32'd0;
      bus.d_ack   <= 1'b0;
      bus.d_err   <= 1'b0;
      bus.d_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= BUSY;
            own         <= d_win;
            tcnt        <= 10'd0;
            bus.m_valid <= 1'b1;
            if (d_win) begin
              bus.m_we    <= bus.d_we;
              bus.m_addr  <= bus.d_addr;
              bus.m_wdata <= bus.d_wdata;
              if (!bus.i_req)
                streak <= 4'd0;
              else if (streak != STREAK_MAX)
                streak <= streak + 4'd1;
            end else begin
              bus.m_we    <= 1'b0;
              bus.m_addr  <= bus.i_addr;
              bus.m_wdata <= 32'd0;
              streak      <= 4'd0;
            end
          end
        end

        BUSY: begin
          // A ready arriving on the last permitted cycle still completes normally.
          if (bus.m_ready || (tcnt == TCNT_LAST)) begin
            state       <= RESP;
            bus.m_valid <= 1'b0;
            if (own) begin
              bus.d_ack   <= 1'b1;
              bus.d_err   <= ~bus.m_ready;
              bus.d_rdata <= (bus.m_ready && !bus.m_we) ? bus.m_rdata : 32'd0;
            end else begin
              bus.i_ack   <= 1'b1;
              bus.i_err   <= ~bus.m_ready;
              bus.i_rdata <= bus.m_ready ? bus.m_rdata : 32'd0;
            end
          end else begin
            tcnt <= tcnt + 10'd1;
          end
        end

        RESP: begin
          state     <= IDLE;
          bus.i_ack <= 1'b0;
          bus.d_ack <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct { logic is_d; logic [31:0] rdata; logic err; int lat; } ack_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int len; } burst_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;

  ack_t   exp_ack[$];
  burst_t exp_m[$];
  req_t   iq[$];
  req_t   dq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic i_pend, i_done, d_pend, d_done;
  int   i_pres, d_pres;
  int   wait_cfg;
  bit   stuck;
  bit   addr_data;
  logic [31:0] mem_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(logic is_d, logic we, logic [31:0] addr, logic [31:0] wdata,
                          int len, logic [31:0] rdata, logic err, int lat);
    burst_t b;
    ack_t   a;
    b.we = we; b.addr = addr; b.wdata = wdata; b.len = len;
    a.is_d = is_d; a.rdata = rdata; a.err = err; a.lat = lat;
    exp_m.push_back(b);
    exp_ack.push_back(a);
  endtask

  task automatic push_req(logic is_d, logic we, logic [31:0] addr, logic [31:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    if (is_d) dq.push_back(r);
    else      iq.push_back(r);
  endtask

  task automatic wait_done(string name, int budget);
    int n;
    n = 0;
    while ((iq.size() != 0 || dq.size() != 0 || i_pend || d_pend ||
            exp_ack.size() != 0 || exp_m.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out after %0d cycles, %0d acks and %0d bursts outstanding",
               name, n, exp_ack.size(), exp_m.size());
      exp_ack.delete();
      exp_m.delete();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Requester drivers: hold req until ack, then next request or deassert in the cycle after.
  initial begin
    req_t r;
    bus.i_req = 1'b0; bus.i_addr = 32'd0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
    i_pend = 1'b0; i_done = 1'b0; d_pend = 1'b0; d_done = 1'b0;
    i_pres = 0; d_pres = 0;
    forever begin
      @(posedge clk);
      #1;
      if (i_done) begin i_done = 1'b0; i_pend = 1'b0; bus.i_req = 1'b0; end
      if (d_done) begin d_done = 1'b0; d_pend = 1'b0; bus.d_req = 1'b0; end
      if (!i_pend && iq.size() != 0) begin
        r = iq.pop_front();
        bus.i_req = 1'b1; bus.i_addr = r.addr;
        i_pend = 1'b1; i_pres = cyc;
      end
      if (!d_pend && dq.size() != 0) begin
        r = dq.pop_front();
        bus.d_req = 1'b1; bus.d_we = r.we; bus.d_addr = r.addr; bus.d_wdata = r.wdata;
        d_pend = 1'b1; d_pres = cyc;
      end
    end
  end

  // Monitor plus memory model, all sampled on the falling edge.
  initial begin
    ack_t   a;
    burst_t b;
    logic   prev_v, cur_we, held;
    logic [31:0] cur_addr, cur_wdata;
    int cur_len, mcnt;
    bus.m_ready = 1'b0; bus.m_rdata = 32'd0;
    prev_v = 1'b0; cur_we = 1'b0; held = 1'b1; cur_addr = 32'd0; cur_wdata = 32'd0;
    cur_len = 0; mcnt = 0;
    forever begin
      @(negedge clk);
      if (bus.i_ack === 1'b1 && bus.d_ack === 1'b1) chk("both_acks", 32'd1, 32'd0);
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        if (exp_ack.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: got i_ack=%b d_ack=%b expected none (cycle %0d)",
                   bus.i_ack, bus.d_ack, cyc);
        end else begin
          a = exp_ack.pop_front();
          chk("ack_owner", {31'd0, bus.d_ack}, {31'd0, a.is_d});
          if (a.is_d) begin
            chk("d_rdata", bus.d_rdata, a.rdata);
            chk("d_err", {31'd0, bus.d_err}, {31'd0, a.err});
          end else begin
            chk("i_rdata", bus.i_rdata, a.rdata);
            chk("i_err", {31'd0, bus.i_err}, {31'd0, a.err});
          end
          if (a.lat >= 0)
            chk("ack_latency", 32'(cyc - (a.is_d ? d_pres : i_pres)), 32'(a.lat));
        end
        if (bus.i_ack === 1'b1) i_done = 1'b1;
        if (bus.d_ack === 1'b1) d_done = 1'b1;
      end

      if (bus.m_valid === 1'b1) begin
        if (!prev_v) begin
          cur_we = bus.m_we; cur_addr = bus.m_addr; cur_wdata = bus.m_wdata;
          cur_len = 1; held = 1'b1;
        end else begin
          cur_len++;
          if (bus.m_we !== cur_we || bus.m_addr !== cur_addr || bus.m_wdata !== cur_wdata)
            held = 1'b0;
        end
      end else if (prev_v) begin
        if (exp_m.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_burst: got addr %h expected none", cur_addr);
        end else begin
          b = exp_m.pop_front();
          chk("m_addr", cur_addr, b.addr);
          chk("m_we", {31'd0, cur_we}, {31'd0, b.we});
          chk("m_wdata", cur_wdata, b.wdata);
          chk("m_valid_len", 32'(cur_len), 32'(b.len));
          chk("m_hold", {31'd0, held}, 32'd1);
        end
      end
      prev_v = (bus.m_valid === 1'b1);

      if (bus.m_valid === 1'b1) begin
        bus.m_ready = !stuck && (mcnt == wait_cfg);
        bus.m_rdata = addr_data ? {16'hA5A5, bus.m_addr[15:0]} : mem_data;
        mcnt++;
      end else begin
        bus.m_ready = 1'b0;
        mcnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wait_cfg = 0; stuck = 1'b0; addr_data = 1'b0; mem_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_m_we", {31'd0, bus.m_we}, 32'd0);
    chk("rst_m_addr", bus.m_addr, 32'd0);
    chk("rst_m_wdata", bus.m_wdata, 32'd0);
    chk("rst_i_ack", {31'd0, bus.i_ack}, 32'd0);
    chk("rst_d_ack", {31'd0, bus.d_ack}, 32'd0);
    chk("rst_i_err", {31'd0, bus.i_err}, 32'd0);
    chk("rst_d_err", {31'd0, bus.d_err}, 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_streak", {28'd0, dut.streak}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Single fetch, zero-wait memory.
    mem_data = 32'h0050_0093;
    push_exp(1'b0, 1'b0, 32'h100, 32'd0, 1, 32'h0050_0093, 1'b0, 2);
    push_req(1'b0, 1'b0, 32'h100, 32'd0);
    wait_done("single_fetch", 40);

    // Store then load, two wait states; store returns zero despite nonzero bus data.
    wait_cfg = 2; mem_data = 32'h1234_5678;
    push_exp(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 3, 32'd0, 1'b0, 4);
    push_req(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    wait_done("store", 40);
    mem_data = 32'hDEAD_BEEF;
    push_exp(1'b1, 1'b0, 32'h40, 32'd0, 3, 32'hDEAD_BEEF, 1'b0, 4);
    push_req(1'b1, 1'b0, 32'h40, 32'd0);
    wait_done("load", 40);

    // Contention: expected grant order D,D,D,D,I,D,D,D,D,I.
    wait_cfg = 0; addr_data = 1'b1;
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 4; k++) begin
        push_exp(1'b1, 1'b0, 32'h1000 + 32'(16 * g + 4 * k), 32'd0, 1,
                 32'hA5A5_1000 + 32'(16 * g + 4 * k), 1'b0, -1);
        push_req(1'b1, 1'b0, 32'h1000 + 32'(16 * g + 4 * k), 32'd0);
      end
      push_exp(1'b0, 1'b0, 32'h300 + 32'(4 * g), 32'd0, 1, 32'hA5A5_0300 + 32'(4 * g), 1'b0, -1);
      push_req(1'b0, 1'b0, 32'h300 + 32'(4 * g), 32'd0);
    end
    wait_done("streak", 200);
    addr_data = 1'b0;

    // Timeout with memory stuck, then a normal fetch.
    stuck = 1'b1; mem_data = 32'hBAD0_BAD0;
    push_exp(1'b0, 1'b0, 32'h200, 32'd0, 8, 32'd0, 1'b1, 9);
    push_req(1'b0, 1'b0, 32'h200, 32'd0);
    wait_done("timeout", 60);
    stuck = 1'b0; mem_data = 32'h00A0_0113;
    push_exp(1'b0, 1'b0, 32'h204, 32'd0, 1, 32'h00A0_0113, 1'b0, 2);
    push_req(1'b0, 1'b0, 32'h204, 32'd0);
    wait_done("after_timeout", 40);

    // Ready on the final allowed BUSY cycle beats the timeout.
    wait_cfg = 7; mem_data = 32'h0C0F_FEE0;
    push_exp(1'b1, 1'b0, 32'h208, 32'd0, 8, 32'h0C0F_FEE0, 1'b0, 9);
    push_req(1'b1, 1'b0, 32'h208, 32'd0);
    wait_done("ready_at_timeout", 60);

    // Fetch acked, dropped next cycle, pending data granted right after RESP.
    wait_cfg = 0; mem_data = 32'h1111_2222;
    push_exp(1'b0, 1'b0, 32'h500, 32'd0, 1, 32'h1111_2222, 1'b0, 2);
    push_exp(1'b1, 1'b0, 32'h600, 32'd0, 1, 32'h1111_2222, 1'b0, 4);
    push_req(1'b0, 1'b0, 32'h500, 32'd0);
    @(posedge clk); #2;
    push_req(1'b1, 1'b0, 32'h600, 32'd0);
    wait_done("ack_regrant", 40);

    // One-cycle reset in the middle of a waited load abandons it without an ack.
    begin
      burst_t b;
      int n;
      wait_cfg = 5; mem_data = 32'h7777_7777;
      b.we = 1'b0; b.addr = 32'h700; b.wdata = 32'd0; b.len = 2;
      exp_m.push_back(b);
      push_req(1'b1, 1'b0, 32'h700, 32'd0);
      n = 0;
      while (bus.m_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("reset_load_started", {31'd0, bus.m_valid}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.d_req = 1'b0; d_pend = 1'b0; d_done = 1'b0;
      @(posedge clk);
      wait_cfg = 0; mem_data = 32'h0010_0073;
      push_exp(1'b0, 1'b0, 32'h800, 32'd0, 1, 32'h0010_0073, 1'b0, 2);
      push_req(1'b0, 1'b0, 32'h800, 32'd0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_m_valid", {31'd0, bus.m_valid}, 32'd0);
      chk("reset_d_ack", {31'd0, bus.d_ack}, 32'd0);
      chk("reset_streak", {28'd0, dut.streak}, 32'd0);
      wait_done("after_reset", 40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
